bus_timer: RTL and testbench
============================

BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h40000000, meaning the word-aligned base of the register window.
REQ-002 SHALL have parameter PRESCALE, default 1, meaning enabled clk cycles per TL increment; legal range 1..65535.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning the asynchronous, active-low reset.
REQ-005 SHALL have port MemRead, input, 1, meaning a CPU load in the MEM stage.
REQ-006 SHALL have port MemWrite, input, 1, meaning a CPU store in the MEM stage.
REQ-007 SHALL have port address, input, 32, meaning the byte address; bits [1:0] are ignored.
REQ-008 SHALL have port write_data, input, 32, meaning the store data.
REQ-009 SHALL have port read_data, output, 32, meaning the load data, combinational.
REQ-010 SHALL have port hit, output, 1, meaning the address decodes to a mapped register of this block.
REQ-011 SHALL have port irq, output, 1, meaning the interrupt request to the CPU control logic.

Function
REQ-012 SHALL decode TH at BASE+0x0, TL at BASE+0x4, TCON at BASE+0x8; any other address gives hit=0 and read_data=0.
REQ-013 SHALL complete every access in zero wait states: reads are combinational in the same cycle; writes commit at the next rising edge when MemWrite=1 and hit=1.
REQ-014 SHALL return read_data=0 when MemRead=0; TCON reads as {29'b0, status, ie, en}.
REQ-015 SHALL decrement the 16-bit prescale counter each cycle while en=1; at terminal count it SHALL reload PRESCALE-1 and advance TL by one.
REQ-016 SHALL, when an advance finds TL=32'hFFFFFFFF, load TL with TH instead of incrementing, and set status if ie=1.
REQ-017 SHALL drive irq = ie & status, registered with no further delay.
REQ-018 SHALL clear the prescale counter to PRESCALE-1 when en=0; TL holds its value.
REQ-019 SHALL, on a TCON write, load en and ie from bits [1:0]; write_data[2]=0 clears status, write_data[2]=1 leaves it unchanged.
REQ-020 SHALL let a TL write win over a same-cycle advance or reload; the prescale counter is not disturbed.
REQ-021 SHALL let a same-cycle overflow set win over a status-clearing TCON write.
REQ-022 SHALL have a TH write take effect on the next reload only; an in-flight count is unchanged.
REQ-023 SHALL, when PRESCALE=1, advance TL every enabled cycle.

Reset
REQ-024 SHALL, while reset=0 (asynchronous), force TH=0, TL=0, TCON=0, prescale counter=PRESCALE-1, and irq=0; read_data and hit follow the inputs combinationally.
REQ-025 SHALL abandon any in-flight count when reset asserts mid-operation; after release, the block counts only after software sets en.

Configuration
REQ-026 SHALL, with BUS_TIMER_SYSTICK_EN defined, add a read-only free-running 32-bit SYSTICK counter at BASE+0xC: reset to 0, +1 every cycle, wrapping, writes ignored.
REQ-027 SHALL, without BUS_TIMER_SYSTICK_EN, leave BASE+0xC unmapped (hit=0) and contain no SYSTICK logic.

Structure
REQ-028 SHALL place register offsets (0x0/0x4/0x8/0xC), TCON bit indices and the default base in a shared package bus_timer_pkg, which the bus decoder also uses.
REQ-029 SHALL isolate the prescaler as sub-module timer_prescaler (inputs en, clk, reset; output tick).

Verification
REQ-030 SHALL test reset: reset=0 mid-count -> TL=0, TCON=0, irq=0 immediately, without waiting for a clock edge.
REQ-031 SHALL test reload: TH=32'hFFFFFFF0, TL=32'hFFFFFFFE, TCON=3, PRESCALE=1 -> TL=FFFFFFFF at edge 1, TL=FFFFFFF0 and irq=1 at edge 2.
REQ-032 SHALL test the clear race: overflow and a TCON write of 3 in the same cycle -> status=1 and irq stays 1; a later write of 3 alone clears irq.
REQ-033 SHALL test the prescaler: PRESCALE=4, en set, TL=0 -> TL=1 after 4 cycles, 2 after 8; clearing en for 2 cycles then setting it -> next increment after 4 more cycles.
REQ-034 SHALL test the write race: a TL write of 32'h12345678 on an advance cycle -> TL=12345678 at the next edge.
REQ-035 SHALL test decode: a read of BASE+0x10 -> hit=0, read_data=0; a read of BASE+0xC -> hit follows BUS_TIMER_SYSTICK_EN, and the value increments by 1 per cycle when enabled.

Source files
------------

// File: rtl/bus_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_timer_pkg
// Description : Shared register map, TCON bit positions and address decode
//               helper for the bus_timer block.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_timer_pkg;

    localparam logic [31:0] c_default_base = 32'h4000_0000;

    // Byte offsets of the register window
    localparam logic [31:0] c_off_th      = 32'h0;
    localparam logic [31:0] c_off_tl      = 32'h4;
    localparam logic [31:0] c_off_tcon    = 32'h8;
    localparam logic [31:0] c_off_systick = 32'hC;

    // TCON bit positions
    localparam int c_tcon_en     = 0;
    localparam int c_tcon_ie     = 1;
    localparam int c_tcon_status = 2;

    typedef enum logic [2:0] {
        SEL_NONE    = 3'd0,
        SEL_TH      = 3'd1,
        SEL_TL      = 3'd2,
        SEL_TCON    = 3'd3,
        SEL_SYSTICK = 3'd4
    } reg_sel_e;

    // Word-granular decode: byte-lane bits never reach this function
    function automatic reg_sel_e decode_reg(input logic [29:0] word,
                                            input logic [29:0] base_word);
        logic [29:0] off;
        off = word - base_word;
        if (off == 30'(c_off_th >> 2))           return SEL_TH;
        else if (off == 30'(c_off_tl >> 2))      return SEL_TL;
        else if (off == 30'(c_off_tcon >> 2))    return SEL_TCON;
        else if (off == 30'(c_off_systick >> 2)) return SEL_SYSTICK;
        else                                     return SEL_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : timer_prescaler
// Description : Down-counting prescaler; pulses tick once every PRESCALE
//               enabled cycles and parks at PRESCALE-1 while disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam logic [15:0] c_reload = 16'(PRESCALE - 1);

    logic [15:0] r_cnt;

    assign tick = en && (r_cnt == 16'd0);

    // Count down while enabled; reload at terminal count or when disabled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= c_reload;
        end else if (!en || (r_cnt == 16'd0)) begin
            r_cnt <= c_reload;
        end else begin
            r_cnt <= r_cnt - 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_timer.sv
`default_nettype none
// ============================================================================
// Module      : bus_timer
// Description : Memory-mapped reloading 32-bit timer (TH/TL/TCON) with a
//               prescaler and level interrupt. Zero-wait-state bus access.
//               Optional feature macro BUS_TIMER_SYSTICK_EN adds a read-only
//               free-running SYSTICK counter at BASE+0xC.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = c_default_base,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        hit,
    output logic        irq
);

    reg_sel_e    w_sel;
    logic        w_hit;
    logic [31:0] w_rdata;
    logic [31:0] w_tcon;

    logic [31:0] r_th;
    logic [31:0] r_tl;
    logic        r_en;
    logic        r_ie;
    logic        r_status;
    logic        r_irq;

    logic        w_tick;
    logic        w_wr_th;
    logic        w_wr_tl;
    logic        w_wr_tcon;
    logic        w_ovf_set;
    logic        w_en_nxt;
    logic        w_ie_nxt;
    logic        w_status_nxt;

    assign w_sel = decode_reg(address[31:2], BASE_ADDR[31:2]);

`ifdef BUS_TIMER_SYSTICK_EN
    logic [31:0] r_systick;

    // Free-running cycle counter, wraps naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_systick <= '0;
        end else begin
            r_systick <= r_systick + 32'd1;
        end
    end

    assign w_hit = (w_sel != SEL_NONE);
`else
    assign w_hit = (w_sel != SEL_NONE) && (w_sel != SEL_SYSTICK);
`endif

    assign hit = w_hit;

    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (r_en),
        .tick  (w_tick)
    );

    // Assemble TCON and the combinational read mux
    always_comb begin
        w_tcon                = '0;
        w_tcon[c_tcon_en]     = r_en;
        w_tcon[c_tcon_ie]     = r_ie;
        w_tcon[c_tcon_status] = r_status;
        w_rdata               = '0;
        if (MemRead) begin
            case (w_sel)
                SEL_TH:      w_rdata = r_th;
                SEL_TL:      w_rdata = r_tl;
                SEL_TCON:    w_rdata = w_tcon;
`ifdef BUS_TIMER_SYSTICK_EN
                SEL_SYSTICK: w_rdata = r_systick;
`endif
                default:     w_rdata = '0;
            endcase
        end
    end

    assign read_data = w_rdata;

    assign w_wr_th   = MemWrite && (w_sel == SEL_TH);
    assign w_wr_tl   = MemWrite && (w_sel == SEL_TL);
    assign w_wr_tcon = MemWrite && (w_sel == SEL_TCON);

    // Overflow only counts when the reload really happens (a TL write wins);
    // an overflow set beats a same-cycle status clear.
    assign w_ovf_set    = w_tick && (&r_tl) && r_ie && !w_wr_tl;
    assign w_en_nxt     = w_wr_tcon ? write_data[c_tcon_en] : r_en;
    assign w_ie_nxt     = w_wr_tcon ? write_data[c_tcon_ie] : r_ie;
    assign w_status_nxt = w_ovf_set ||
                          (r_status && !(w_wr_tcon && !write_data[c_tcon_status]));

    // Timer registers: TL write beats advance/reload; TH used only at reload
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_th     <= '0;
            r_tl     <= '0;
            r_en     <= 1'b0;
            r_ie     <= 1'b0;
            r_status <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_th) begin
                r_th <= write_data;
            end
            if (w_wr_tl) begin
                r_tl <= write_data;
            end else if (w_tick) begin
                r_tl <= (&r_tl) ? r_th : (r_tl + 32'd1);
            end
            r_en     <= w_en_nxt;
            r_ie     <= w_ie_nxt;
            r_status <= w_status_nxt;
            r_irq    <= w_ie_nxt && w_status_nxt;
        end
    end

    assign irq = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_bus_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_timer
// Description : Self-checking bench for bus_timer. Two instances (PRESCALE
//               1 and 4) share one bus and are compared against a cycle-level
//               reference model. Honours BUS_TIMER_SYSTICK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_timer;

    localparam logic [31:0] BASE = 32'h4000_0000;
`ifdef BUS_TIMER_SYSTICK_EN
    localparam bit c_systick = 1'b1;
`else
    localparam bit c_systick = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] rd1, rd4;
    logic        hit1, hit4, irq1, irq4;

    always #5 clk = ~clk;

    bus_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .address(address), .write_data(write_data),
        .read_data(rd1), .hit(hit1), .irq(irq1)
    );

    bus_timer #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .address(address), .write_data(write_data),
        .read_data(rd4), .hit(hit4), .irq(irq4)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned m_p [2] = '{1, 4};
    logic [31:0] m_th [2];
    logic [31:0] m_tl [2];
    bit          m_en [2];
    bit          m_ie [2];
    bit          m_st [2];
    int unsigned m_phase [2];   // enabled cycles since the last advance
    logic [31:0] m_systick;
    logic [31:0] last_rd [2];

    function automatic int m_reg(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (off[31:4] != 28'd0) return -1;
        if (off[3:2] == 2'd3)   return c_systick ? 3 : -1;
        return int'(off[3:2]);
    endfunction

    function automatic logic [31:0] m_read(input int i, input bit rd, input logic [31:0] a);
        if (!rd) return 32'd0;
        case (m_reg(a))
            0:       return m_th[i];
            1:       return m_tl[i];
            2:       return 32'(4 * m_st[i] + 2 * m_ie[i] + m_en[i]);
            3:       return m_systick;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_th[i] = '0; m_tl[i] = '0; m_en[i] = 0; m_ie[i] = 0; m_st[i] = 0; m_phase[i] = 0;
        end
        m_systick = '0;
    endtask

    task automatic m_step(input bit wr, input logic [31:0] a, input logic [31:0] wd);
        int  r;
        bit  w, adv, ovf;
        r = m_reg(a);
        w = wr && (r >= 0);
        for (int i = 0; i < 2; i++) begin
            adv = 0;
            ovf = 0;
            if (m_en[i]) begin
                m_phase[i]++;
                if (m_phase[i] == m_p[i]) begin
                    adv = 1;
                    m_phase[i] = 0;
                end
            end else begin
                m_phase[i] = 0;
            end
            if (w && r == 1) begin
                m_tl[i] = wd;
            end else if (adv) begin
                if (m_tl[i] == 32'hFFFF_FFFF) begin
                    m_tl[i] = m_th[i];
                    ovf = 1;
                end else begin
                    m_tl[i] = m_tl[i] + 1;
                end
            end
            if (ovf && m_ie[i])                 m_st[i] = 1;
            else if (w && r == 2 && !wd[2])     m_st[i] = 0;
            if (w && r == 0) m_th[i] = wd;
            if (w && r == 2) begin
                m_en[i] = wd[0];
                m_ie[i] = wd[1];
            end
        end
        m_systick = m_systick + 1;
    endtask

    // ---------------- bus cycle ----------------
    // Called just after a rising edge: drive, sample combinational outputs,
    // take the edge, advance the model, then check irq.
    task automatic cycle(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
        MemRead    = rd;
        MemWrite   = wr;
        address    = a;
        write_data = wd;
        #1;
        last_rd[0] = rd1;
        last_rd[1] = rd4;
        check("hit1",  {31'b0, hit1}, {31'b0, m_reg(a) >= 0});
        check("hit4",  {31'b0, hit4}, {31'b0, m_reg(a) >= 0});
        check("rdata1", rd1, m_read(0, rd, a));
        check("rdata4", rd4, m_read(1, rd, a));
        @(posedge clk);
        m_step(wr, a, wd);
        #1;
        check("irq1", {31'b0, irq1}, {31'b0, m_ie[0] & m_st[0]});
        check("irq4", {31'b0, irq4}, {31'b0, m_ie[1] & m_st[1]});
    endtask

    task automatic wr_reg(input logic [31:0] off, input logic [31:0] d);
        cycle(1'b0, 1'b1, BASE + off, d);
    endtask

    task automatic rd_reg(input logic [31:0] off);
        cycle(1'b1, 1'b0, BASE + off, 32'd0);
    endtask

    logic [31:0] ra, rdat;
    int          rk;

    initial begin
        reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; address = '0; write_data = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #2;
        // Reset state, read combinationally while held in reset
        MemRead = 1'b1; address = BASE + 32'h4;
        #1;
        check("rst_tl",   rd1, 32'd0);
        check("rst_hit",  {31'b0, hit1}, 32'd1);
        check("rst_irq",  {31'b0, irq1}, 32'd0);
        address = BASE + 32'h8;
        #1;
        check("rst_tcon", rd4, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Reload scenario on the PRESCALE=1 instance
        wr_reg(32'h0, 32'hFFFF_FFF0);
        wr_reg(32'h4, 32'hFFFF_FFFE);
        wr_reg(32'h8, 32'd3);
        rd_reg(32'h4);
        check("rel_tl0", last_rd[0], 32'hFFFF_FFFE);
        rd_reg(32'h4);
        check("rel_tl1", last_rd[0], 32'hFFFF_FFFF);
        check("rel_irq", {31'b0, irq1}, 32'd1);
        rd_reg(32'h4);
        check("rel_tl2", last_rd[0], 32'hFFFF_FFF0);

        // Asynchronous reset mid-count, checked between edges
        MemRead = 1'b1; MemWrite = 1'b0; address = BASE + 32'h4;
        #1 reset = 1'b0;
        #1;
        check("amid_tl1",  rd1, 32'd0);
        check("amid_tl4",  rd4, 32'd0);
        check("amid_irq1", {31'b0, irq1}, 32'd0);
        address = BASE + 32'h8;
        #1;
        check("amid_tcon", rd1, 32'd0);
        m_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        rd_reg(32'h4);
        rd_reg(32'h4);
        check("post_rst_tl", last_rd[0], 32'd0);

        // Overflow set racing a status-clearing TCON write
        wr_reg(32'h0, 32'd0);
        wr_reg(32'h8, 32'd3);
        wr_reg(32'h4, 32'hFFFF_FFFF);
        wr_reg(32'h8, 32'd3);
        check("race_irq", {31'b0, irq1}, 32'd1);
        rd_reg(32'h8);
        check("race_tcon", last_rd[0], 32'd7);
        wr_reg(32'h8, 32'd3);
        check("clr_irq", {31'b0, irq1}, 32'd0);

        // TL write racing an advance
        wr_reg(32'h4, 32'h1234_5678);
        rd_reg(32'h4);
        check("wrrace_tl", last_rd[0], 32'h1234_5678);

        // Prescaler behaviour on the PRESCALE=4 instance
        wr_reg(32'h8, 32'd0);
        wr_reg(32'h4, 32'd0);
        wr_reg(32'h8, 32'd1);
        for (int i = 0; i <= 8; i++) begin
            rd_reg(32'h4);
            check($sformatf("psc_tl_%0d", i), last_rd[1], 32'(i / 4));
        end
        wr_reg(32'h8, 32'd0);
        cycle(1'b0, 1'b0, BASE, 32'd0);
        cycle(1'b0, 1'b0, BASE, 32'd0);
        wr_reg(32'h8, 32'd1);
        for (int i = 0; i <= 4; i++) begin
            rd_reg(32'h4);
            check($sformatf("psc_re_%0d", i), last_rd[1], (i < 4) ? 32'd2 : 32'd3);
        end

        // Decode
        rd_reg(32'h10);
        check("dec10_hit", {31'b0, hit1}, 32'd0);
        check("dec10_rd",  last_rd[0], 32'd0);
        rd_reg(32'hC);
        check("decC_hit", {31'b0, hit1}, {31'b0, c_systick});
        rd_reg(32'hC);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            rk   = int'($urandom_range(0, 9));
            ra   = BASE + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
            rdat = $urandom;
            if ($urandom_range(0, 15) == 0) ra = $urandom;
            case (rk)
                0: cycle(1'b0, 1'b1, BASE + 32'h4, 32'hFFFF_FFFF - 32'($urandom_range(0, 6)));
                1: cycle(1'b0, 1'b1, BASE + 32'h8,
                         {29'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 7) != 0)});
                2: cycle(1'b0, 1'b1, BASE, rdat);
                9: cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rdat);
                default: cycle(1'b1, 1'b0, ra, 32'd0);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
